tff_count_ctrl: RTL and testbench
=================================

// Module: tff_count_ctrl
// PURPOSE
//  Sequencer for a bank of WIDTH external t_flipflop cells (q <= q ^ t on posedge clk).
//  Computes the per-bit toggle vector each cycle, so the bank acts as a synchronous
//  up/down modulo-N counter with clear, parallel load, hold and one-shot/continuous modes.
//  Sits between control logic and the flip-flop bank and owns no count state itself.
//  The bank has no reset, so this block clears it after reset.
// PARAMETERS
//  WIDTH    4   bank width / count bits (2..16)
// PORTS
//  clk       in   1      rising-edge clock, shared with the flip-flop bank
//  rst_n     in   1      asynchronous active-low reset
//  start     in   1      begin/resume counting (level sampled per cycle)
//  stop      in   1      abort to IDLE; count frozen
//  hold      in   1      pause while high (RUN<->PAUSE)
//  up_dn     in   1      1 = count up, 0 = count down (sampled every cycle)
//  one_shot  in   1      1 = stop at terminal value, 0 = wrap and continue
//  modulus   in   WIDTH  count range 0..modulus-1; 0 means 2**WIDTH
//  load      in   1      parallel load request
//  load_val  in   WIDTH  value to load
//  q_vec     in   WIDTH  current bank outputs (q of each cell)
//  t_vec     out  WIDTH  toggle inputs to bank (t of each cell), combinational
//  busy      out  1      state is RUN or PAUSE
//  tc        out  1      registered 1-cycle pulse: terminal step taken
//  done      out  1      registered 1-cycle pulse: one-shot completed
// BEHAVIOUR
//  - Reset (rst_n low): state=INIT; busy=0, tc=0, done=0; t_vec=0 while rst_n low.
//  - t_vec selects bank next state: t_vec = q_vec ^ next. Hold means t_vec=0.
//    Bank updates on the same edge, so latency is 0 cycles from t_vec to the new q.
//  - Terminal value: TV = modulus-1 when up_dn=1; TV = 0 when up_dn=0. M = modulus or 2**WIDTH.
//  - FSM states: INIT, IDLE, RUN, PAUSE, DONE.
//    INIT:  t_vec = q_vec (clears bank to 0). Next state is IDLE. One cycle only.
//    IDLE:  t_vec=0. start -> RUN.
//    RUN:   counting step every cycle. hold -> PAUSE. stop -> IDLE.
//    PAUSE: t_vec=0. hold low with start high -> RUN. Otherwise stay. stop -> IDLE.
//    DONE:  t_vec=0. start -> RUN (count resumes from held value). stop -> IDLE.
//  - Priority in the same cycle: stop > load > hold > start.
//    stop in any state: t_vec=0 and next state IDLE.
//  - load in IDLE/RUN/PAUSE/DONE: t_vec = q_vec ^ load_val. State unchanged, except DONE -> IDLE.
//    The load replaces that cycle's count step. No tc. load in INIT is ignored.
//  - RUN count step when q_vec /= TV:
//    up: next = q+1, t[i] = &q[i-1:0] (t[0]=1).
//    down: next = q-1, t[i] = &~q[i-1:0].
//  - RUN count step when q_vec == TV:
//    continuous: wrap (next = 0 up / M-1 down). tc=1 next cycle.
//    one_shot: t_vec=0 (count holds at TV). State -> DONE. tc=1 and done=1 next cycle.
//  - Out of range (q_vec >= M, e.g. after a load): in RUN, next = 0 (up) or M-1 (down).
//    This is not a terminal step: no tc.
//  - Entering RUN with q_vec already at TV in one_shot mode: first RUN cycle completes
//    immediately (DONE, done pulse).
//  - up_dn or modulus change mid-run: takes effect on the next step. No glitch state.
//  - Async reset mid-operation: outputs return to reset values immediately.
//    After release, INIT clears the bank again.
//  - All arithmetic modulo 2**WIDTH. t_vec depends only on state, q_vec and inputs:
//    no comb loop exists unless the bank is transparent.
// TESTING  (WIDTH=4, bench instantiates 4 t_flipflop cells driven by t_vec)
//  1. Release rst_n with random bank contents -> 1 cycle later q_vec=0.
//     busy=0. t_vec=0 thereafter.
//  2. modulus=10, up, continuous, start 1 cycle:
//     q sequence 0,1,..,9,0,1. tc pulses once, in the cycle after 9->0.
//  3. modulus=0, down, one_shot, load_val=3 then start:
//     q sequence 3,2,1,0 then holds 0. done=tc=1 for 1 cycle. State DONE, busy=0.
//  4. In RUN at q=5: hold high 3 cycles -> q stays 5.
//     hold low with start -> 6,7. stop at q=7 -> q stays 7, busy=0.
//  5. Same cycle stop+load(9) -> no load, IDLE.
//     load(12) with modulus=10, then RUN up -> q 12,0,1 and no tc.
//  6. Assert rst_n low mid-count at q=6 -> tc/done/busy 0 immediately.
//     After release -> q=0 via INIT, then IDLE.

Source files
------------

// File: rtl/tff_count_ctrl.sv
// Toggle-vector sequencer for a bank of external T flip-flops.
// The bank holds the count; this block decides each cycle which cells toggle
// so that the bank's next value is a clear, load, hold or modulo up/down count step.
module tff_count_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             up_dn,
  input  logic             one_shot,
  input  logic [WIDTH-1:0] modulus,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] q_vec,
  output logic [WIDTH-1:0] t_vec,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] next_val;

  logic [WIDTH-1:0] mod_m1;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] wrap_val;
  logic             out_of_range;

  // Count arithmetic; modulus 0 wraps naturally to all-ones, i.e. M = 2**WIDTH.
  always_comb begin
    mod_m1       = modulus - WIDTH'(1);
    term_val     = up_dn ? mod_m1 : '0;
    step_val     = up_dn ? (q_vec + WIDTH'(1)) : (q_vec - WIDTH'(1));
    wrap_val     = up_dn ? '0 : mod_m1;
    out_of_range = (modulus != '0) && (q_vec >= modulus);
  end

  // Next-state and desired next bank value; default leaves the bank untouched.
  always_comb begin
    state_d  = state_q;
    next_val = q_vec;
    tc_d     = 1'b0;
    done_d   = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_INIT) begin
      // The bank has no reset of its own: clear it on the first cycle out of reset.
      next_val = '0;
      state_d  = ST_IDLE;
    end else if (load) begin
      next_val = load_val;
      if (state_q == ST_DONE) begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (hold) begin
            state_d = ST_PAUSE;
          end else if (out_of_range) begin
            // Recovery from an out-of-range load is not a terminal step.
            next_val = wrap_val;
          end else if (q_vec == term_val) begin
            tc_d = 1'b1;
            if (one_shot) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              next_val = wrap_val;
            end
          end else begin
            next_val = step_val;
          end
        end
        ST_PAUSE: begin
          if (!hold && start) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if (start) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
  end

  // Toggle only the bits that differ; forced quiet while reset is asserted.
  always_comb begin
    t_vec = rst_n ? (q_vec ^ next_val) : '0;
  end

  // State and registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign tc   = tc_q;
  assign done = done_q;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Bench for tff_count_ctrl: a 4-cell T flip-flop bank driven by t_vec, directed
// stimulus with hand-computed expectations queued to a separate monitor.
module tb_tff_count_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start, stop, hold, up_dn, one_shot, load;
  logic [3:0] modulus, load_val;
  logic [3:0] t_vec;
  logic       busy, tc, done;

  // Bank of T flip-flops without reset; starts with arbitrary contents.
  logic [3:0] bank_q = 4'b1011;
  always @(posedge clk) bank_q <= bank_q ^ t_vec;

  tff_count_ctrl #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .hold     (hold),
    .up_dn    (up_dn),
    .one_shot (one_shot),
    .modulus  (modulus),
    .load     (load),
    .load_val (load_val),
    .q_vec    (bank_q),
    .t_vec    (t_vec),
    .busy     (busy),
    .tc       (tc),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] q;
    logic       busy;
    logic       tc;
    logic       done;
    logic       chk_t;
    logic [3:0] t;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  event mon_tick;

  // Sample point: 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    -> mon_tick;
  end

  // Monitor: compare DUT/bank state against the oldest queued expectation.
  initial begin
    forever begin
      @(mon_tick);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (bank_q !== e.q || busy !== e.busy || tc !== e.tc || done !== e.done ||
            (e.chk_t && t_vec !== e.t)) begin
          errors++;
          $display("FAIL %s: got q=%h busy=%b tc=%b done=%b t=%h, expected q=%h busy=%b tc=%b done=%b t=%h",
                   e.name, bank_q, busy, tc, done, t_vec, e.q, e.busy, e.tc, e.done, e.t);
        end
      end
    end
  end

  // Queue the expectation for the next sample point, then advance to the next falling edge.
  task automatic expect_cyc(input string nm, input logic [3:0] eq, input logic eb,
                            input logic etc, input logic ed, input logic [3:0] et);
    exp_t e;
    e.name = nm; e.q = eq; e.busy = eb; e.tc = etc; e.done = ed; e.chk_t = 1'b1; e.t = et;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus.
  initial begin
    logic [3:0] qv, nv;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0; load = 1'b0;
    up_dn = 1'b1; one_shot = 1'b0; modulus = 4'd10; load_val = 4'd0;
    @(negedge clk);
    @(negedge clk);

    // Reset: bank untouched while reset is held, then cleared by INIT.
    expect_cyc("rst_hold", 4'hB, 1'b0, 1'b0, 1'b0, 4'h0);
    rst_n = 1'b1;
    expect_cyc("init_clear", 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    expect_cyc("idle", 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);

    // Modulo-10 up, continuous.
    start = 1'b1;
    expect_cyc("run_enter", 4'h0, 1'b1, 1'b0, 1'b0, 4'h1);
    start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      qv = 4'(i);
      nv = (i == 9) ? 4'd0 : 4'(i + 1);
      expect_cyc("up_cnt", qv, 1'b1, 1'b0, 1'b0, qv ^ nv);
    end
    expect_cyc("up_wrap", 4'h0, 1'b1, 1'b1, 1'b0, 4'h1);
    expect_cyc("up_after", 4'h1, 1'b1, 1'b0, 1'b0, 4'h3);
    stop = 1'b1;
    expect_cyc("stop1", 4'h1, 1'b0, 1'b0, 1'b0, 4'h0);
    stop = 1'b0;

    // Full-range down, one-shot from a loaded 3.
    modulus = 4'd0; up_dn = 1'b0; one_shot = 1'b1; load = 1'b1; load_val = 4'd3;
    expect_cyc("load3", 4'h3, 1'b0, 1'b0, 1'b0, 4'h0);
    load = 1'b0; start = 1'b1;
    expect_cyc("os_enter", 4'h3, 1'b1, 1'b0, 1'b0, 4'h1);
    start = 1'b0;
    expect_cyc("dn2", 4'h2, 1'b1, 1'b0, 1'b0, 4'h3);
    expect_cyc("dn1", 4'h1, 1'b1, 1'b0, 1'b0, 4'h1);
    expect_cyc("dn0", 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
    expect_cyc("os_done", 4'h0, 1'b0, 1'b1, 1'b1, 4'h0);
    expect_cyc("os_hold", 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);

    // Resume from DONE, hold/pause, then stop.
    modulus = 4'd10; up_dn = 1'b1; one_shot = 1'b0; start = 1'b1;
    expect_cyc("resume", 4'h0, 1'b1, 1'b0, 1'b0, 4'h1);
    start = 1'b0;
    expect_cyc("up1", 4'h1, 1'b1, 1'b0, 1'b0, 4'h3);
    expect_cyc("up2", 4'h2, 1'b1, 1'b0, 1'b0, 4'h1);
    expect_cyc("up3", 4'h3, 1'b1, 1'b0, 1'b0, 4'h7);
    expect_cyc("up4", 4'h4, 1'b1, 1'b0, 1'b0, 4'h1);
    expect_cyc("up5", 4'h5, 1'b1, 1'b0, 1'b0, 4'h3);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) expect_cyc("hold", 4'h5, 1'b1, 1'b0, 1'b0, 4'h0);
    hold = 1'b0; start = 1'b1;
    expect_cyc("unpause", 4'h5, 1'b1, 1'b0, 1'b0, 4'h3);
    expect_cyc("up6", 4'h6, 1'b1, 1'b0, 1'b0, 4'h1);
    expect_cyc("up7", 4'h7, 1'b1, 1'b0, 1'b0, 4'hF);
    start = 1'b0; stop = 1'b1;
    expect_cyc("stop7", 4'h7, 1'b0, 1'b0, 1'b0, 4'h0);

    // stop beats load; then out-of-range load recovers to 0 without tc.
    load = 1'b1; load_val = 4'd9;
    expect_cyc("stop_load", 4'h7, 1'b0, 1'b0, 1'b0, 4'h0);
    stop = 1'b0; load_val = 4'd12;
    expect_cyc("load12", 4'hC, 1'b0, 1'b0, 1'b0, 4'h0);
    load = 1'b0; start = 1'b1;
    expect_cyc("oor_enter", 4'hC, 1'b1, 1'b0, 1'b0, 4'hC);
    start = 1'b0;
    expect_cyc("oor0", 4'h0, 1'b1, 1'b0, 1'b0, 4'h1);
    expect_cyc("oor1", 4'h1, 1'b1, 1'b0, 1'b0, 4'h3);
    expect_cyc("up2b", 4'h2, 1'b1, 1'b0, 1'b0, 4'h1);
    expect_cyc("up3b", 4'h3, 1'b1, 1'b0, 1'b0, 4'h7);
    expect_cyc("up4b", 4'h4, 1'b1, 1'b0, 1'b0, 4'h1);
    expect_cyc("up5b", 4'h5, 1'b1, 1'b0, 1'b0, 4'h3);
    expect_cyc("up6b", 4'h6, 1'b1, 1'b0, 1'b0, 4'h1);

    // Async reset mid-count: outputs drop before any clock edge.
    rst_n = 1'b0;
    #1;
    begin
      exp_t e;
      e.name = "rst_async"; e.q = 4'h6; e.busy = 1'b0; e.tc = 1'b0; e.done = 1'b0;
      e.chk_t = 1'b1; e.t = 4'h0;
      exp_q.push_back(e);
      -> mon_tick;
    end
    @(negedge clk);
    expect_cyc("rst_low", 4'h6, 1'b0, 1'b0, 1'b0, 4'h0);
    rst_n = 1'b1;
    expect_cyc("rst_init", 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    expect_cyc("rst_idle", 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);

    // Down, continuous: wrap from 0 to modulus-1 with tc.
    up_dn = 1'b0; start = 1'b1;
    expect_cyc("dn_enter", 4'h0, 1'b1, 1'b0, 1'b0, 4'h9);
    start = 1'b0;
    expect_cyc("dn_wrap", 4'h9, 1'b1, 1'b1, 1'b0, 4'h1);
    expect_cyc("dn8", 4'h8, 1'b1, 1'b0, 1'b0, 4'hF);
    stop = 1'b1;
    expect_cyc("stop_end", 4'h8, 1'b0, 1'b0, 1'b0, 4'h0);
    stop = 1'b0;
    @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked expectations, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
